// File: rtl/spi_seq_pkg.sv
// Shared types and constants for the SPI configuration sequencer.
// FSM state encoding, data width and the default init table contents.
package spi_seq_pkg;

    localparam int SPI_WORD_W = 16;

    typedef enum logic [2:0] {
        S_START,
        S_ISSUE,
        S_WAIT_LOW,
        S_WAIT_HIGH,
        S_GAP,
        S_READY
    } spi_seq_state_t;

    localparam logic [SPI_WORD_W-1:0] SPI_INIT_W0 = 16'h0F01;
    localparam logic [SPI_WORD_W-1:0] SPI_INIT_W1 = 16'h1020;
    localparam logic [SPI_WORD_W-1:0] SPI_INIT_W2 = 16'h2133;
    localparam logic [SPI_WORD_W-1:0] SPI_INIT_W3 = 16'h2200;
    localparam logic [SPI_WORD_W-1:0] SPI_INIT_W4 = 16'h2380;
    localparam logic [SPI_WORD_W-1:0] SPI_INIT_W5 = 16'h2407;
    localparam logic [SPI_WORD_W-1:0] SPI_INIT_W6 = 16'h30FF;
    localparam logic [SPI_WORD_W-1:0] SPI_INIT_W7 = 16'h3F00;

endpackage

// File: rtl/spi_init_rom.sv
// Combinational init-table ROM: index in, 16-bit register word out.
// Entries beyond the default table read as zero.
module spi_init_rom
    import spi_seq_pkg::*;
(
    input  logic [3:0]            idx,
    output logic [SPI_WORD_W-1:0] word
);

    always_comb begin
        word = '0;
        case (idx)
            4'd0:    word = SPI_INIT_W0;
            4'd1:    word = SPI_INIT_W1;
            4'd2:    word = SPI_INIT_W2;
            4'd3:    word = SPI_INIT_W3;
            4'd4:    word = SPI_INIT_W4;
            4'd5:    word = SPI_INIT_W5;
            4'd6:    word = SPI_INIT_W6;
            4'd7:    word = SPI_INIT_W7;
            default: word = '0;
        endcase
    end

endmodule

// File: rtl/spi_cfg_sequencer.sv
// Streams the init table to spi_write after reset, then forwards host writes.
// Optional per-frame ORDY watchdog enabled by defining SPI_SEQ_TIMEOUT_EN.
module spi_cfg_sequencer
    import spi_seq_pkg::*;
#(
    parameter int N_WORDS    = 8,
    parameter int GAP_CYCLES = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic                  ORDY,
    output logic                  GO,
    output logic [SPI_WORD_W-1:0] regdata,
    input  logic                  host_req,
    input  logic [SPI_WORD_W-1:0] host_data,
    output logic                  host_ack,
    output logic                  init_done,
    output logic                  busy,
    output logic [3:0]            word_idx,
    output logic                  err
);

    localparam logic [3:0] LAST_IDX = 4'(N_WORDS - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

    spi_seq_state_t        state_q, state_d;
    logic [SPI_WORD_W-1:0] regdata_q, regdata_d;
    logic [3:0]            word_idx_q, word_idx_d;
    logic [7:0]            gap_q, gap_d;
    logic                  src_host_q, src_host_d;
    logic                  init_done_q, init_done_d;
    logic                  host_ack_q, host_ack_d;
    logic                  frame_end;
    logic [3:0]            rom_addr;
    logic [SPI_WORD_W-1:0] rom_word;

    // In S_GAP the word being loaded is the next one, not the current index.
    assign rom_addr = (state_q == S_GAP) ? word_idx_q + 4'd1 : word_idx_q;

    spi_init_rom u_rom (
        .idx  (rom_addr),
        .word (rom_word)
    );

`ifdef SPI_SEQ_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
    logic [15:0] tmo_q, tmo_d;
    logic        err_q, err_d;
`endif

    always_comb begin
        state_d     = state_q;
        regdata_d   = regdata_q;
        word_idx_d  = word_idx_q;
        gap_d       = gap_q;
        src_host_d  = src_host_q;
        init_done_d = init_done_q;
        host_ack_d  = 1'b0;
        frame_end   = 1'b0;
        case (state_q)
            S_START: begin
                if (ORDY) begin
                    regdata_d  = rom_word;
                    src_host_d = 1'b0;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE:     state_d = S_WAIT_LOW;
            S_WAIT_LOW:  if (!ORDY) state_d = S_WAIT_HIGH;
            S_WAIT_HIGH: if (ORDY) frame_end = 1'b1;
            S_GAP: begin
                if (gap_q == 8'd0) begin
                    if (src_host_q) begin
                        state_d = S_READY;
                    end else if (word_idx_q < LAST_IDX) begin
                        word_idx_d = word_idx_q + 4'd1;
                        regdata_d  = rom_word;
                        state_d    = S_ISSUE;
                    end else begin
                        init_done_d = 1'b1;
                        state_d     = S_READY;
                    end
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            S_READY: begin
                if (host_req) begin
                    regdata_d  = host_data;
                    src_host_d = 1'b1;
                    state_d    = S_ISSUE;
                end
            end
            default: state_d = S_START;
        endcase
`ifdef SPI_SEQ_TIMEOUT_EN
        tmo_d = 16'd0;
        err_d = err_q;
        if (state_q == S_WAIT_LOW || state_q == S_WAIT_HIGH) begin
            if (tmo_q == TMO_LAST) begin
                err_d     = 1'b1;
                frame_end = 1'b1;
            end else begin
                tmo_d = tmo_q + 16'd1;
            end
        end
`endif
        // A timed-out frame is retired exactly like a completed one.
        if (frame_end) begin
            state_d    = S_GAP;
            gap_d      = GAP_LAST;
            host_ack_d = src_host_q;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q     <= S_START;
            regdata_q   <= '0;
            word_idx_q  <= 4'd0;
            gap_q       <= 8'd0;
            src_host_q  <= 1'b0;
            init_done_q <= 1'b0;
            host_ack_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            regdata_q   <= regdata_d;
            word_idx_q  <= word_idx_d;
            gap_q       <= gap_d;
            src_host_q  <= src_host_d;
            init_done_q <= init_done_d;
            host_ack_q  <= host_ack_d;
        end
    end

`ifdef SPI_SEQ_TIMEOUT_EN
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            tmo_q <= 16'd0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign GO        = (state_q == S_ISSUE);
    assign busy      = (state_q != S_READY);
    assign regdata   = regdata_q;
    assign word_idx  = word_idx_q;
    assign init_done = init_done_q;
    assign host_ack  = host_ack_q;

endmodule
